// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB-style memory responder.
package apb_mem_pkg;

  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned CNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/apb_mem_array.sv
// Word storage: synchronous write, combinational read, cleared on reset.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Clear every word on reset, otherwise write the addressed word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_mem_responder.sv
// Memory responder with wait states and completion counters.
// Build option: define APB_MEM_WAIT_EN to insert WAIT_CYCLES wait states;
// without it a request goes straight from IDLE to RESP.
module apb_mem_responder
  import apb_mem_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  wr_rd_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      rdata_o,
  output logic [CNT_W-1:0]      wr_count_o,
  output logic [CNT_W-1:0]      rd_count_o
);

`ifdef APB_MEM_WAIT_EN
  localparam bit USE_WAIT = (WAIT_CYCLES != 0);
`else
  // WAIT_CYCLES has no effect in this build.
  localparam bit USE_WAIT = 1'b0 && (WAIT_CYCLES != 0);
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, req_addr;
  logic [WIDTH-1:0]      wdata_q, rdata_q, mem_rdata;
  logic                  wr_q, req_wr;
  logic                  ready_q, ready_d;
  logic [CNT_W-1:0]      wr_cnt_q, rd_cnt_q;
  logic                  accept, wait_done, mem_we, rd_load;

  assign accept   = (state_q == IDLE) && valid_i;
  // In IDLE the request is still on the inputs; afterwards use the capture.
  assign req_addr = (state_q == IDLE) ? addr_i  : addr_q;
  assign req_wr   = (state_q == IDLE) ? wr_rd_i : wr_q;

  if (USE_WAIT) begin : g_wait
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;

    // Load on acceptance, count down while waiting.
    always_comb begin
      cnt_d = cnt_q;
      if (accept)                                cnt_d = CW'(WAIT_CYCLES - 1);
      else if (state_q == WAIT && cnt_q != '0)   cnt_d = cnt_q - CW'(1);
    end

    // Wait counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign wait_done = (cnt_q == '0);
  end else begin : g_no_wait
    assign wait_done = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state; dropping valid while waiting aborts the request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = USE_WAIT ? WAIT : RESP;
      WAIT:    if (!valid_i) state_d = IDLE;
               else if (wait_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready for the RESP cycle, commit on RESP exit.
  always_comb begin
    ready_d = (state_d == RESP);
    mem_we  = (state_q == RESP) && wr_q;
    rd_load = (state_q != RESP) && (state_d == RESP) && !req_wr;
  end

  // Capture request fields at the accepting edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      wr_q    <= wr_rd_i;
    end
  end

  // Registered ready/rdata and completion counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      ready_q <= ready_d;
      if (rd_load) rdata_q <= mem_rdata;
      if (state_q == RESP) begin
        if (wr_q) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        else      rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
    end
  end

  apb_mem_array #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (req_addr),
    .rdata_o (mem_rdata)
  );

  assign ready_o    = ready_q;
  assign rdata_o    = rdata_q;
  assign wr_count_o = wr_cnt_q;
  assign rd_count_o = rd_cnt_q;

endmodule

// File: doc/apb_mem_responder.md
APB_MEM_RESPONDER -- requirements
Module: apb_mem_responder

Interface
REQ-001 Parameters: WIDTH, default 16, data width; ADDR_WIDTH, default 4, address width (depth 2**ADDR_WIDTH); WAIT_CYCLES, default 2, wait states before ready.
REQ-002 clk  input  1  single clock; all state on posedge clk.
REQ-003 rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 addr  input  ADDR_WIDTH  word address, sampled with valid.
REQ-005 wdata  input  WIDTH  write data.
REQ-006 wr_rd  input  1  1 = write, 0 = read.
REQ-007 valid  input  1  initiator request; held high with addr/wdata/wr_rd stable until ready seen.
REQ-008 ready  output  1  registered; one-cycle completion strobe.
REQ-009 rdata  output  WIDTH  registered read data, valid in the ready cycle of a read.
REQ-010 wr_count  output  8  completed writes, wraps 255->0.
REQ-011 rd_count  output  8  completed reads, wraps 255->0.

Function
REQ-012 FSM states: IDLE, WAIT, RESP.
REQ-013 IDLE: valid=1 sampled at edge N -> WAIT with wait counter loaded to WAIT_CYCLES-1 (RESP if WAIT_CYCLES==0); request fields captured at edge N.
REQ-014 WAIT: counter decrements each cycle; at 0 -> RESP.
REQ-015 RESP: ready=1 for exactly one cycle, asserted WAIT_CYCLES+1 cycles after the valid-sampling edge; next state IDLE unconditionally.
REQ-016 Write completes in RESP: mem[captured addr] <= captured wdata at the RESP-exit edge; wr_count increments at the same edge.
REQ-017 Read: rdata loaded with mem[captured addr] on entry to RESP; rd_count increments at the RESP-exit edge; rdata holds its value until the next read.
REQ-018 valid low in WAIT: abort to IDLE next edge, no memory update, no counter change, no ready.
REQ-019 Back-to-back requests: at least one IDLE cycle between ready and the next acceptance; valid high in the ready cycle is treated as a new request only if still high in IDLE.
REQ-020 Write followed by read to the same address returns the new data.
REQ-021 Address covers the full depth; no out-of-range condition.

Reset
REQ-022 rst low (asynchronous): FSM IDLE, ready=0, rdata=0, wr_count=0, rd_count=0, wait counter=0, all memory words 0.
REQ-023 Reset mid-transaction discards the transaction: no write, no ready after release.
REQ-024 First acceptance possible at the first posedge after rst deasserts.

Configuration
REQ-025 Macro APB_MEM_WAIT_EN: defined -> WAIT state and counter implemented per REQ-013/014; undefined -> WAIT removed, IDLE goes directly to RESP, ready one cycle after the valid-sampling edge, WAIT_CYCLES ignored.

Structure
REQ-026 Package apb_mem_pkg holds the FSM state typedef (IDLE/WAIT/RESP), default WIDTH/ADDR_WIDTH constants and the counter width constant (8).
REQ-027 Sub-module apb_mem_array: storage array with synchronous write port, combinational read port and reset clear; the FSM and counters stay in the top.

Verification (WIDTH=16, ADDR_WIDTH=4, WAIT_CYCLES=2, APB_MEM_WAIT_EN defined unless noted)
REQ-028 Write addr=3 wdata=16'hA5A5, then read addr=3 -> ready 3 cycles after each acceptance; read rdata=16'hA5A5; wr_count=1, rd_count=1.
REQ-029 Read addr=7 straight after reset -> rdata=16'h0000, ready exactly one cycle wide.
REQ-030 Write addr=5 with valid dropped after 1 WAIT cycle, then read addr=5 -> no ready for the write, rdata=0, wr_count=0.
REQ-031 rst asserted during WAIT of a write to addr=2 wdata=16'h1234 -> ready=0 immediately; after release, read addr=2 returns 16'h0000.
REQ-032 256 consecutive writes -> wr_count wraps to 0; the 257th write makes it 1.
REQ-033 APB_MEM_WAIT_EN undefined: write addr=15 wdata=16'hFFFF -> ready 1 cycle after acceptance; read back returns 16'hFFFF.
